msk_out_unshare_serializer: RTL and testbench

- Receiver for the masked AES core's output side. Accepts one shared 128-bit result over the core's out_valid/out_ready handshake.
- Recombines the shares by XOR and streams the unmasked block as four 32-bit words over a valid/ready/last stream.
- Sits between the core's sh_data_out port and a word-wide host/readback interface. It is the hardware counterpart of the bench-side output checker.

---
 rtl/msk_out_unshare_serializer.sv | 107 ++++++++++
 tb/tb_msk_out_unshare_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/msk_out_unshare_serializer.sv
// msk_out_unshare_serializer
// Takes one d-share masked 128-bit AES result from the core's output
// handshake and recombines the shares by XOR. It then streams the unmasked
// block as four big-endian (FIPS byte order) 32-bit words with a last flag.
//
// Optional build macro: MSK_OUT_ZEROIZE_EN
//   defined   - the held block is cleared after its last word is read out,
//               unless a new block is accepted in the same cycle.
//   undefined - the held block stays until the next accept or reset.
//
// state | meaning
// IDLE  | no block held, ready to accept a shared block
// EMIT  | block held, presenting word cnt on the output stream
module msk_out_unshare_serializer #(
  parameter int d = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [128*d-1:0] sh_data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t       state;
  logic [1:0]   cnt;
  logic [127:0] buffer;
  logic [127:0] rec;
  logic [31:0]  word_raw;
  logic         accept;
  logic         word_hs;
  logic         on_last;

  // Recombine the shares: bit i of share j sits at index i*d+j
  always_comb begin
    rec = '0;
    for (int i = 0; i < 128; i++) begin
      for (int j = 0; j < d; j++) begin
        rec[i] = rec[i] ^ sh_data_in[i*d+j];
      end
    end
  end

  assign on_last   = (state == EMIT) && (cnt == 2'd3);
  assign out_valid = (state == EMIT);
  assign out_last  = on_last;
  assign busy      = (state == EMIT);

  // Ready in IDLE, or cut-through while the last word is being taken;
  // held low during reset so the core cannot hand over a block then
  assign in_ready = !rst && ((state == IDLE) || (on_last && out_ready));

  assign accept  = in_valid && in_ready;
  assign word_hs = out_valid && out_ready;

  // Select word cnt and reorder bytes so the lowest-addressed byte is MSB
  always_comb begin
    word_raw = buffer[{cnt, 5'd0} +: 32];
    out_data = {word_raw[7:0], word_raw[15:8], word_raw[23:16], word_raw[31:24]};
  end

  // Block capture, word sequencing and return to idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      buffer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            buffer <= rec;
            cnt    <= 2'd0;
            state  <= EMIT;
          end
        end
        EMIT: begin
          if (word_hs) begin
            if (cnt != 2'd3) begin
              cnt <= cnt + 2'd1;
            end else if (accept) begin
              buffer <= rec;
              cnt    <= 2'd0;
            end else begin
              cnt   <= 2'd0;
              state <= IDLE;
`ifdef MSK_OUT_ZEROIZE_EN
              buffer <= '0;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msk_out_unshare_serializer.sv
// Self-checking bench for msk_out_unshare_serializer (three shares).
module tb_msk_out_unshare_serializer;
  localparam int D = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [128*D-1:0] sh_data_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_last;
  logic             busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  msk_out_unshare_serializer #(.d(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sh_data_in (sh_data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  typedef struct packed {
    logic [127:0]     ct;
    logic [127:0]     m1;
    logic [127:0]     m2;
    logic [3:0][31:0] w;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIPS hex literal (byte 0 leftmost) -> block with byte 0 in bits [7:0]
  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = h[127-8*b -: 8];
    return r;
  endfunction

  function automatic logic [128*D-1:0] encode(input logic [127:0] blk, input logic [127:0] m1,
                                              input logic [127:0] m2);
    logic [127:0]     s [D];
    logic [128*D-1:0] bus;
    s[0] = blk ^ m1 ^ m2;
    s[1] = m1;
    s[2] = m2;
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < D; j++) bus[i*D+j] = s[j][i];
    return bus;
  endfunction

  // Word k of a block: bytes 4k..4k+3, lowest byte most significant
  function automatic logic [31:0] ref_word(input logic [127:0] blk, input int k);
    int v = 0;
    for (int b = 0; b < 4; b++) v = v * 256 + int'(blk[8*(4*k+b) +: 8]);
    return v;
  endfunction

  // Hand over one block with out_ready=1 and check its four words
  task automatic run_block(input logic [128*D-1:0] sh, input logic [3:0][31:0] w, input string tag);
    @(negedge clk);
    in_valid = 1'b1; sh_data_in = sh; out_ready = 1'b1;
    #1 chk({tag, " idle in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("%s word%0d data", tag, k), out_data, w[k]);
      chk($sformatf("%s word%0d valid", tag, k), out_valid, 1);
      chk($sformatf("%s word%0d last", tag, k), out_last, (k == 3));
      chk($sformatf("%s word%0d in_ready", tag, k), in_ready, (k == 3));
      chk($sformatf("%s word%0d busy", tag, k), busy, 1);
      @(negedge clk);
    end
    #1;
    chk({tag, " end valid"}, out_valid, 0);
    chk({tag, " end busy"}, busy, 0);
  endtask

  logic [127:0] r0, r2;
  logic [127:0] mask_a5, mask_ramp;
  logic [32:0]  q [$];

  initial begin
    mask_a5   = {16{8'ha5}};
    mask_ramp = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    r0 = fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    r2 = fips(128'h00112233445566778899aabbccddeeff);

    vecs[0].ct = r0; vecs[0].m1 = '0;      vecs[0].m2 = '0;
    vecs[0].w[0] = 32'h69c4e0d8; vecs[0].w[1] = 32'h6a7b0430;
    vecs[0].w[2] = 32'hd8cdb780; vecs[0].w[3] = 32'h70b4c55a;
    vecs[1].ct = r0; vecs[1].m1 = mask_a5; vecs[1].m2 = mask_ramp;
    vecs[1].w = vecs[0].w;
    vecs[2].ct = r2; vecs[2].m1 = mask_ramp; vecs[2].m2 = ~mask_a5;
    vecs[2].w[0] = 32'h00112233; vecs[2].w[1] = 32'h44556677;
    vecs[2].w[2] = 32'h8899aabb; vecs[2].w[3] = 32'hccddeeff;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sh_data_in = '0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_last", out_last, 0);
    chk("reset out_data", out_data, 0);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 0);
    rst = 1'b0;
    #1 chk("post-reset in_ready", in_ready, 1);

    for (int v = 0; v < 3; v++)
      run_block(encode(vecs[v].ct, vecs[v].m1, vecs[v].m2), vecs[v].w, $sformatf("vec%0d", v));

    // Readout finished with no new block: check what remains held
`ifdef MSK_OUT_ZEROIZE_EN
    chk("zeroize buffer", dut.buffer, 0);
    chk("zeroize out_data", out_data, 0);
`else
    chk("retain buffer", dut.buffer, r2);
    chk("retain out_data", out_data, 32'h00112233);
`endif

    // Back pressure on word 1
    @(negedge clk);
    in_valid = 1'b1; sh_data_in = encode(r0, mask_a5, mask_ramp); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("bp word0", out_data, 32'h69c4e0d8);
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp hold%0d data", c), out_data, 32'h6a7b0430);
      chk($sformatf("bp hold%0d valid", c), out_valid, 1);
      chk($sformatf("bp hold%0d last", c), out_last, 0);
      chk($sformatf("bp hold%0d in_ready", c), in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp release word1", out_data, 32'h6a7b0430);
    @(negedge clk);
    #1 chk("bp word2", out_data, 32'hd8cdb780);
    @(negedge clk);
    #1 chk("bp word3", out_data, 32'h70b4c55a);
    chk("bp word3 last", out_last, 1);
    @(negedge clk);
    #1 chk("bp end valid", out_valid, 0);

    // Back-to-back blocks with cut-through accept
    @(negedge clk);
    in_valid = 1'b1; sh_data_in = encode(r0, '0, mask_a5); out_ready = 1'b1;
    @(negedge clk);
    sh_data_in = encode(r2, mask_a5, mask_ramp);
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("b2b cyc%0d data", c), out_data, (c < 4) ? vecs[0].w[c] : vecs[2].w[c-4]);
      chk($sformatf("b2b cyc%0d valid", c), out_valid, 1);
      chk($sformatf("b2b cyc%0d busy", c), busy, 1);
      chk($sformatf("b2b cyc%0d last", c), out_last, (c == 3 || c == 7));
      chk($sformatf("b2b cyc%0d in_ready", c), in_ready, (c == 3 || c == 7));
      @(negedge clk);
      if (c == 3) in_valid = 1'b0;
    end
    #1 chk("b2b end busy", busy, 0);

    // Asynchronous reset after the word 1 handshake
    @(negedge clk);
    in_valid = 1'b1; sh_data_in = encode(r0, mask_ramp, mask_a5); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst mid out_valid", out_valid, 0);
    chk("rst mid busy", busy, 0);
    chk("rst mid in_ready", in_ready, 0);
    chk("rst mid out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst release in_ready", in_ready, 1);
    chk("rst release valid", out_valid, 0);
    @(negedge clk);
    #1 chk("rst no stale valid", out_valid, 0);
    run_block(encode(r2, mask_ramp, '0), vecs[2].w, "after_rst");

    // Randomized traffic against a word-queue reference model
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [127:0] blk, m1, m2;
      logic         exp_v, exp_ir, iv, ordy;
      @(negedge clk);
      blk = {$urandom, $urandom, $urandom, $urandom};
      m1  = {$urandom, $urandom, $urandom, $urandom};
      m2  = {$urandom, $urandom, $urandom, $urandom};
      iv   = ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      in_valid = iv; out_ready = ordy; sh_data_in = encode(blk, m1, m2);
      #1;
      exp_v  = (q.size() > 0);
      exp_ir = (q.size() == 0) || (q.size() == 1 && ordy);
      chk($sformatf("rnd%0d in_ready", cyc), in_ready, exp_ir);
      chk($sformatf("rnd%0d valid", cyc), out_valid, exp_v);
      chk($sformatf("rnd%0d busy", cyc), busy, exp_v);
      if (exp_v) begin
        chk($sformatf("rnd%0d data", cyc), out_data, q[0][31:0]);
        chk($sformatf("rnd%0d last", cyc), out_last, q[0][32]);
      end
      @(posedge clk);
      if (exp_v && ordy) void'(q.pop_front());
      if (iv && exp_ir)
        for (int k = 0; k < 4; k++) q.push_back({(k == 3), ref_word(blk, k)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
